// File: rtl/posit_field_extract_if.sv
// Handshake bundle for posit_field_extract: decode-side input beat and registered output beat.
interface posit_field_extract_if #(
  parameter int N  = 32,
  parameter int ES = 2
);
  localparam int RS = $clog2(N);
  localparam int FW = N - 3 - ES;

  logic                in_valid;
  logic                in_ready;
  logic                in_sign;
  logic [N-2:0]        in_remain;
  logic [RS:0]         in_end_position;
  logic                in_regime_check;

  logic                out_valid;
  logic                out_ready;
  logic                out_sign;
  logic [RS:0]         out_k;
  logic [ES-1:0]       out_exp;
  logic [FW:0]         out_mant;
  logic [RS+ES+1:0]    out_sf;
  logic                out_zero;
  logic                out_nar;

  modport master (
    output in_valid, in_sign, in_remain, in_end_position, in_regime_check, out_ready,
    input  in_ready, out_valid, out_sign, out_k, out_exp, out_mant, out_sf, out_zero, out_nar
  );

  modport slave (
    input  in_valid, in_sign, in_remain, in_end_position, in_regime_check, out_ready,
    output in_ready, out_valid, out_sign, out_k, out_exp, out_mant, out_sf, out_zero, out_nar
  );
endinterface

// File: rtl/posit_field_extract.sv
// Posit regime/exponent/fraction extractor behind a valid/ready output register.
// Define PFE_TWO_STAGE_EN to register the regime decode separately (2-cycle latency, 2 beats).
module posit_field_extract #(
  parameter int N  = 32,
  parameter int ES = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  posit_field_extract_if.slave bus
);
  localparam int RS = $clog2(N);
  localparam int FW = N - 3 - ES;
  localparam int SW = RS + ES + 2;

  typedef logic [RS:0]           pos_t;
  typedef logic [N-4:0]          tail_t;
  typedef logic signed [SW-1:0]  sf_t;

  localparam pos_t M_MAX = pos_t'(N - 1);

  // Stage A: regime decode. The regime always eats at least two body bits, so only
  // in_remain[N-4:0] is carried forward and the shift amount is reduced by two.
  pos_t  m_a, k_a, shamt_a;
  logic  zero_a, nar_a;

  always_comb begin
    m_a = bus.in_end_position;
    if (m_a == '0 || m_a > M_MAX) m_a = M_MAX;
    k_a     = bus.in_regime_check ? m_a - pos_t'(1) : pos_t'(0) - m_a;
    shamt_a = (m_a == M_MAX) ? m_a - pos_t'(2) : m_a - pos_t'(1);
    zero_a  = (bus.in_remain == '0) && !bus.in_sign;
    nar_a   = (bus.in_remain == '0) && bus.in_sign;
  end

  logic  out_valid_q, out_valid_d;
  logic  load_b;
  logic  sign_b, zero_b, nar_b;
  pos_t  k_b, shamt_b;
  tail_t tail_b;

`ifdef PFE_TWO_STAGE_EN
  logic  a_valid_q, a_valid_d;
  logic  a_sign_q, a_zero_q, a_nar_q;
  pos_t  a_k_q, a_shamt_q;
  tail_t a_tail_q;
  logic  b_ready, in_fire;

  assign b_ready      = !out_valid_q || bus.out_ready;
  assign bus.in_ready = !a_valid_q || b_ready;
  assign in_fire      = bus.in_valid && bus.in_ready;
  assign load_b       = a_valid_q && b_ready;

  always_comb begin
    a_valid_d = a_valid_q;
    if (in_fire)     a_valid_d = 1'b1;
    else if (load_b) a_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid_q <= 1'b0;
      a_sign_q  <= 1'b0;
      a_zero_q  <= 1'b0;
      a_nar_q   <= 1'b0;
      a_k_q     <= '0;
      a_shamt_q <= '0;
      a_tail_q  <= '0;
    end else begin
      a_valid_q <= a_valid_d;
      if (in_fire) begin
        a_sign_q  <= bus.in_sign;
        a_zero_q  <= zero_a;
        a_nar_q   <= nar_a;
        a_k_q     <= k_a;
        a_shamt_q <= shamt_a;
        a_tail_q  <= bus.in_remain[N-4:0];
      end
    end
  end

  assign sign_b  = a_sign_q;
  assign zero_b  = a_zero_q;
  assign nar_b   = a_nar_q;
  assign k_b     = a_k_q;
  assign shamt_b = a_shamt_q;
  assign tail_b  = a_tail_q;
`else
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign load_b       = bus.in_valid && bus.in_ready;
  assign sign_b       = bus.in_sign;
  assign zero_b       = zero_a;
  assign nar_b        = nar_a;
  assign k_b          = k_a;
  assign shamt_b      = shamt_a;
  assign tail_b       = bus.in_remain[N-4:0];
`endif

  // Stage B: field extraction into the output register.
  tail_t          shifted_b;
  logic [ES-1:0]  exp_b;
  logic [FW-1:0]  frac_b;
  logic           special_b;
  sf_t            sf_b;

  always_comb begin
    shifted_b = tail_b << shamt_b;
    {exp_b, frac_b} = shifted_b;
    special_b = zero_b || nar_b;
    sf_b = (sf_t'($signed(k_b)) <<< ES) + sf_t'(exp_b);
    out_valid_d = out_valid_q;
    if (load_b)             out_valid_d = 1'b1;
    else if (bus.out_ready) out_valid_d = 1'b0;
  end

  logic           out_sign_q, out_zero_q, out_nar_q;
  pos_t           out_k_q;
  logic [ES-1:0]  out_exp_q;
  logic [FW:0]    out_mant_q;
  sf_t            out_sf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_sign_q  <= 1'b0;
      out_zero_q  <= 1'b0;
      out_nar_q   <= 1'b0;
      out_k_q     <= '0;
      out_exp_q   <= '0;
      out_mant_q  <= '0;
      out_sf_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      if (load_b) begin
        out_sign_q <= sign_b;
        out_zero_q <= zero_b;
        out_nar_q  <= nar_b;
        out_k_q    <= special_b ? '0 : k_b;
        out_exp_q  <= special_b ? '0 : exp_b;
        out_mant_q <= special_b ? '0 : {1'b1, frac_b};
        out_sf_q   <= special_b ? '0 : sf_b;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sign  = out_sign_q;
  assign bus.out_zero  = out_zero_q;
  assign bus.out_nar   = out_nar_q;
  assign bus.out_k     = out_k_q;
  assign bus.out_exp   = out_exp_q;
  assign bus.out_mant  = out_mant_q;
  assign bus.out_sf    = out_sf_q;
endmodule

// File: tb/tb_posit_field_extract.sv
// Self-checking bench for posit_field_extract: scoreboard of expected beats, one task per scenario.
module tb_posit_field_extract;
  localparam int N = 32;
  localparam int ES = 2;
`ifdef PFE_TWO_STAGE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int CAP = LAT;
  localparam int LIMIT = 200;

  typedef struct packed {
    logic        sign;
    logic [30:0] remain;
    logic [5:0]  m;
    logic        rc;
  } in_t;

  typedef struct packed {
    logic        sign;
    logic [5:0]  k;
    logic [1:0]  exp;
    logic [27:0] mant;
    logic [8:0]  sf;
    logic        zero;
    logic        nar;
  } out_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  in_t  stim_q[$];
  out_t exp_q[$];

  posit_field_extract_if #(.N(N), .ES(ES)) bus();
  posit_field_extract #(.N(N), .ES(ES)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic out_t model(input in_t b);
    out_t   e;
    int     m, k, cons, ex;
    longint v;
    e = '0;
    e.sign = b.sign;
    if (b.remain == 31'd0) begin
      e.zero = !b.sign;
      e.nar  = b.sign;
      return e;
    end
    m = int'(b.m);
    if (m < 1 || m > 31) m = 31;
    k    = b.rc ? m - 1 : -m;
    cons = (m == 31) ? 31 : m + 1;
    v    = (longint'(b.remain) << cons) & 64'h7FFF_FFFF;
    ex   = int'(v >> 29);
    e.k    = 6'(k);
    e.exp  = 2'(ex);
    e.mant = {1'b1, 27'(v >> 2)};
    e.sf   = 9'(k * 4 + ex);
    return e;
  endfunction

  task automatic add(input logic s, input logic [30:0] r, input logic [5:0] m, input logic rc);
    in_t b;
    b = {s, r, m, rc};
    stim_q.push_back(b);
  endtask

  task automatic add_random();
    logic [30:0] r;
    r = 31'($urandom);
    add(1'($urandom), r, 6'($urandom_range(1, 31)), r[30]);
  endtask

  function automatic out_t observe();
    return {bus.out_sign, bus.out_k, bus.out_exp, bus.out_mant, bus.out_sf, bus.out_zero, bus.out_nar};
  endfunction

  // One clock: present the head of stim_q at negedge, sample handshakes, record accepted beats.
  task automatic step(input logic rdy, output bit in_fire, output bit out_fire,
                      output out_t obs, output bit obs_v);
    in_t b;
    @(negedge clk);
    if (stim_q.size() > 0) begin
      b = stim_q[0];
      bus.in_valid = 1'b1;
      bus.in_sign = b.sign;
      bus.in_remain = b.remain;
      bus.in_end_position = b.m;
      bus.in_regime_check = b.rc;
    end else begin
      bus.in_valid = 1'b0;
    end
    bus.out_ready = rdy;
    #1;
    obs_v    = bus.out_valid;
    obs      = observe();
    in_fire  = bus.in_valid && bus.in_ready;
    out_fire = obs_v && rdy;
    if (in_fire) begin
      b = stim_q.pop_front();
      exp_q.push_back(model(b));
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_sign = 1'b0;
    bus.in_remain = '0;
    bus.in_end_position = '0;
    bus.in_regime_check = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || observe() !== '0) begin
      errors++;
      $display("FAIL reset_outputs: out_valid=%b data=%h, required out_valid=0 data=0", bus.out_valid, observe());
    end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1/0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_values();
    bit inf, outf, ov;
    out_t obs;
    int cyc = 0;
    add(1'b0, 31'h4000_0000, 6'd1, 1'b1);   // 1.0
    add(1'b0, 31'h4800_0000, 6'd1, 1'b1);   // 2.0
    add(1'b0, 31'h7FFF_FFFF, 6'd31, 1'b1);  // maxpos
    add(1'b0, 31'h0000_0001, 6'd30, 1'b0);  // minpos
    add(1'b0, 31'h0000_0000, 6'd31, 1'b0);  // zero
    add(1'b1, 31'h0000_0000, 6'd31, 1'b0);  // NaR
    add(1'b1, 31'h1234_5678, 6'd0, 1'b0);   // illegal m, clamped
    add(1'b0, 31'h7FFF_FFF0, 6'd45, 1'b1);  // illegal m, clamped
    add(1'b0, 31'h3ABC_DEF1, 6'd1, 1'b0);
    add(1'b1, 31'h7800_1234, 6'd4, 1'b1);
    while ((stim_q.size() > 0 || exp_q.size() > 0) && cyc < LIMIT) begin
      step(1'b1, inf, outf, obs, ov);
      if (ov) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL values_unexpected: got beat %h, required no beat", obs);
        end else if (obs !== exp_q[0]) begin
          errors++;
          $display("FAIL values_beat: got %h, required %h", obs, exp_q[0]);
        end
        if (outf && exp_q.size() > 0) void'(exp_q.pop_front());
      end
      cyc++;
    end
    checks++;
    if (cyc >= LIMIT) begin
      errors++;
      $display("FAIL values_timeout: %0d beats outstanding, required 0", exp_q.size() + stim_q.size());
    end
  endtask

  task automatic test_back_to_back();
    bit inf, outf, ov;
    out_t obs;
    int cyc = 0;
    for (int i = 0; i < 8; i++) add_random();
    while ((stim_q.size() > 0 || exp_q.size() > 0) && cyc < LIMIT) begin
      step(1'b1, inf, outf, obs, ov);
      if (ov) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_unexpected: got beat %h, required no beat", obs);
        end else if (obs !== exp_q[0]) begin
          errors++;
          $display("FAIL b2b_beat: got %h, required %h", obs, exp_q[0]);
        end
        if (outf && exp_q.size() > 0) void'(exp_q.pop_front());
      end
      cyc++;
    end
    checks++;
    if (cyc != 8 + LAT) begin
      errors++;
      $display("FAIL b2b_cycles: took %0d cycles, required %0d", cyc, 8 + LAT);
    end
  endtask

  task automatic test_backpressure();
    bit inf, outf, ov;
    out_t obs;
    int cyc = 0;
    int seen = 0;
    for (int i = 0; i < 8; i++) add_random();
    while ((stim_q.size() > 0 || exp_q.size() > 0) && cyc < LIMIT) begin
      step(logic'(cyc % 2 == 0), inf, outf, obs, ov);
      if (ov) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL bp_unexpected: got beat %h, required no beat", obs);
        end else if (obs !== exp_q[0]) begin
          errors++;
          $display("FAIL bp_beat: got %h, required %h", obs, exp_q[0]);
        end
        if (outf && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          seen++;
        end
      end
      cyc++;
    end
    checks++;
    if (seen != 8 || cyc >= LIMIT) begin
      errors++;
      $display("FAIL bp_count: delivered %0d beats in %0d cycles, required 8 within %0d", seen, cyc, LIMIT);
    end
  endtask

  task automatic test_reset_inflight();
    bit inf, outf, ov;
    bit stale = 1'b0;
    out_t obs;
    int acc = 0;
    for (int i = 0; i < 4; i++) add_random();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, inf, outf, obs, ov);
      if (inf) acc++;
    end
    #2;
    checks++;
    if (acc != CAP) begin
      errors++;
      $display("FAIL fill_accepted: accepted %0d beats under stall, required %0d", acc, CAP);
    end
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL fill_full: in_ready=%b out_valid=%b, required 0/1", bus.in_ready, bus.out_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || observe() !== '0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: out_valid=%b data=%h in_ready=%b, required 0/0/1",
               bus.out_valid, observe(), bus.in_ready);
    end
    stim_q.delete();
    exp_q.delete();
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, inf, outf, obs, ov);
      if (ov) stale = 1'b1;
    end
    checks++;
    if (stale) begin
      errors++;
      $display("FAIL stale_beat: out_valid=1 after reset release, required 0");
    end
  endtask

  initial begin
    test_reset();
    test_values();
    test_back_to_back();
    test_backpressure();
    test_reset_inflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
